// File: rtl/modexp_sequencer_4bit.sv
// modexp_sequencer_4bit: R = M^E mod N by MSB-first square-and-multiply.
// Drives one external multiplier (mul_en/mul_a/mul_b, result on mul_p when
// mul_done) and reduces every product with an internal bit-serial restoring
// reducer that runs for exactly 2*DATA_W cycles.
//
// Handshake: the job is accepted on a cycle where state is IDLE and start=1.
// A start seen at any other time is ignored. Towards the multiplier, mul_en
// is held high until mul_done=1; the product is captured in that same cycle
// and mul_en drops on the next cycle.
//
// Optional feature macro: MODEXP_LEAD_SKIP_EN. When it is defined, the
// square-and-reduce rounds for the leading exponent bits are skipped while
// the accumulator is still 1. When it is undefined, every exponent bit gets a
// squaring, so the timing does not depend on the leading zeros of E.
module modexp_sequencer_4bit #(
    parameter int DATA_W = 4,
    parameter int EXP_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     msg,
    input  logic [EXP_W-1:0]      exp,
    input  logic [DATA_W-1:0]     modn,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic                  err,
    output logic                  mul_en,
    output logic [DATA_W-1:0]     mul_a,
    output logic [DATA_W-1:0]     mul_b,
    input  logic [2*DATA_W-1:0]   mul_p,
    input  logic                  mul_done
);

    localparam int PW = 2 * DATA_W;
    localparam int CW = $clog2(PW);
    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BRED,
        S_SQ,
        S_SRED,
        S_MU,
        S_MRED,
        S_FIN
    } state_t;

    state_t            state;
    logic [EXP_W-1:0]  exp_r;
    logic [DATA_W-1:0] n_r;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] base;
    logic [PW-1:0]     div;
    logic [DATA_W-1:0] rem;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;

    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_next;
    logic [DATA_W-1:0] red_val;
    logic              red_last;

    // One restoring-division step: shift in the next dividend bit (MSB first),
    // then subtract N if it fits. rem stays below N, so a DATA_W-bit register holds it.
    always_comb begin
        rem_shift = {rem, div[PW-1]};
        rem_next  = rem_shift;
        if (rem_shift >= {1'b0, n_r}) begin
            rem_next = rem_shift - {1'b0, n_r};
        end
        red_val  = rem_next[DATA_W-1:0];
        red_last = (cnt == CW'(PW - 1));
    end

`ifdef MODEXP_LEAD_SKIP_EN
    logic [IW-1:0] msb_idx;

    // Index of the most significant set exponent bit (where leading-bit skipping stops).
    always_comb begin
        msb_idx = '0;
        for (int k = 0; k < EXP_W; k++) begin
            if (exp_r[k]) begin
                msb_idx = IW'(k);
            end
        end
    end
`endif

    // Sequencer FSM: the state and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            mul_en <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
            acc    <= DATA_W'(1);
            base   <= '0;
            exp_r  <= '0;
            n_r    <= '0;
            div    <= '0;
            rem    <= '0;
            cnt    <= '0;
            idx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_r <= exp;
                        n_r   <= modn;
                        acc   <= DATA_W'(1);
                        idx   <= IW'(EXP_W - 1);
                        busy  <= 1'b1;
                        err   <= (modn == '0);
                        cnt   <= '0;
                        rem   <= '0;
                        div   <= {{DATA_W{1'b0}}, msg};
                        if (modn == '0) begin
                            result <= '0;
                            done   <= 1'b1;
                            state  <= S_FIN;
                        end else begin
                            state <= S_BRED;
                        end
                    end
                end

                S_BRED: begin
                    cnt <= cnt + CW'(1);
                    rem <= red_val;
                    div <= div << 1;
                    if (red_last) begin
                        base <= red_val;
`ifdef MODEXP_LEAD_SKIP_EN
                        if (exp_r == '0) begin
                            // acc is still 1 here; N==1 must still give 0
                            result <= (acc >= n_r) ? '0 : acc;
                            done   <= 1'b1;
                            state  <= S_FIN;
                        end else begin
                            // the square at the top set bit is 1*1, so go straight to the multiply
                            idx    <= msb_idx;
                            mul_en <= 1'b1;
                            mul_a  <= acc;
                            mul_b  <= red_val;
                            state  <= S_MU;
                        end
`else
                        mul_en <= 1'b1;
                        mul_a  <= acc;
                        mul_b  <= acc;
                        state  <= S_SQ;
`endif
                    end
                end

                S_SQ, S_MU: begin
                    if (mul_done) begin
                        mul_en <= 1'b0;
                        div    <= mul_p;
                        cnt    <= '0;
                        rem    <= '0;
                        state  <= (state == S_SQ) ? S_SRED : S_MRED;
                    end
                end

                S_SRED, S_MRED: begin
                    cnt <= cnt + CW'(1);
                    rem <= red_val;
                    div <= div << 1;
                    if (red_last) begin
                        acc <= red_val;
                        if (state == S_SRED && exp_r[idx]) begin
                            mul_en <= 1'b1;
                            mul_a  <= red_val;
                            mul_b  <= base;
                            state  <= S_MU;
                        end else if (idx == '0) begin
                            // a reduced value is already below N
                            result <= red_val;
                            done   <= 1'b1;
                            state  <= S_FIN;
                        end else begin
                            idx    <= idx - IW'(1);
                            mul_en <= 1'b1;
                            mul_a  <= red_val;
                            mul_b  <= red_val;
                            state  <= S_SQ;
                        end
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
